instr_mem_arbiter: RTL and testbench

INSTR_MEM_ARBITER -- requirements
Module: instr_mem_arbiter

---
 rtl/riscv_defines.sv | 6 +
 rtl/rr_pick2.sv | 8 +
 rtl/instr_mem_arbiter.sv | 67 ++++++
 tb/tb_instr_mem_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// riscv_defines: shared widths, arbiter state encoding and timeout default.
package riscv_defines;
   localparam int WORD_WIDTH = 32;
   localparam int ARB_TIMEOUT_DEFAULT = 8;
   typedef enum logic {IDLE, WAIT} arb_state_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin selector; on a tie the master not picked last wins.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       sel
);
   assign sel = &req ? ~last : req[1];
endmodule

// File: rtl/instr_mem_arbiter.sv
// instr_mem_arbiter: arbitrates core fetch (m0) and debug/loader (m1) reads onto one
// instruction memory port, one outstanding transaction, with a response timeout.
module instr_mem_arbiter
   import riscv_defines::*;
#(
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req_i,
   input  logic [WORD_WIDTH-1:0] m0_addr_i,
   output logic                  m0_gnt_o,
   output logic                  m0_rvalid_o,
   output logic                  m0_err_o,
   output logic [WORD_WIDTH-1:0] m0_rdata_o,
   input  logic                  m1_req_i,
   input  logic [WORD_WIDTH-1:0] m1_addr_i,
   output logic                  m1_gnt_o,
   output logic                  m1_rvalid_o,
   output logic                  m1_err_o,
   output logic [WORD_WIDTH-1:0] m1_rdata_o,
   output logic                  mem_req_o,
   output logic [WORD_WIDTH-1:0] mem_addr_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [WORD_WIDTH-1:0] mem_rdata_i
);
   // Counter starts at 0 on the first WAIT cycle, so the abort lands TIMEOUT_CYCLES-1 cycles after grant.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 2);
   arb_state_t state_q, state_d;
   logic owner_q, last_q, sel, idle, busy, grant, tmo, done;
   logic [7:0] cnt_q;
   rr_pick2 u_pick (.req({m1_req_i, m0_req_i}), .last(last_q), .sel(sel));
   always_comb begin
      idle = !rst && state_q == IDLE;
      busy = !rst && state_q == WAIT;
      mem_req_o = idle && (m0_req_i || m1_req_i);
      mem_addr_o = !mem_req_o ? '0 : sel ? {m1_addr_i[WORD_WIDTH-1:2], 2'b00} : {m0_addr_i[WORD_WIDTH-1:2], 2'b00};
      grant = mem_req_o && mem_gnt_i;
      m0_gnt_o = grant && !sel;
      m1_gnt_o = grant && sel;
      tmo = busy && cnt_q == TMO_LAST && !mem_rvalid_i;
      done = (busy && mem_rvalid_i) || tmo;
      m0_rvalid_o = done && !owner_q;
      m1_rvalid_o = done && owner_q;
      m0_err_o = tmo && !owner_q;
      m1_err_o = tmo && owner_q;
      m0_rdata_o = (busy && mem_rvalid_i && !owner_q) ? mem_rdata_i : '0;
      m1_rdata_o = (busy && mem_rvalid_i && owner_q) ? mem_rdata_i : '0;
      state_d = grant ? WAIT : done ? IDLE : state_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q <= 1'b1;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            owner_q <= sel;
            last_q <= sel;
            cnt_q <= '0;
         end else if (busy) cnt_q <= cnt_q + 8'd1;
      end
   end
endmodule

// File: tb/tb_instr_mem_arbiter.sv
// tb_instr_mem_arbiter: directed and random checks against a transaction-level model
// of the arbiter and a 1-cycle-latency memory of MEM_WORDS words.
module tb_instr_mem_arbiter;
   import riscv_defines::*;
   localparam int MEM_WORDS = 64;
   localparam int TMO = 8;
   logic clk = 1'b0, rst;
   logic m0_req_i, m0_gnt_o, m0_rvalid_o, m0_err_o, m1_req_i, m1_gnt_o, m1_rvalid_o, m1_err_o;
   logic mem_req_o, mem_gnt_i, mem_rvalid_i;
   logic [31:0] m0_addr_i, m0_rdata_o, m1_addr_i, m1_rdata_o, mem_addr_o, mem_rdata_i;
   instr_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
      .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
      .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );
   always #5 clk = ~clk;
   int vectors = 0, miscompares = 0;
   // Model: is a transaction outstanding, for whom, cycles since its grant, who wins a tie.
   bit busy, mem_resp, stray;
   int who, age, prefer;
   logic [31:0] resp_word;
   logic [31:0] mem [MEM_WORDS];
   logic s_mem_req;
   logic [31:0] s_mem_addr, s_rd0, s_rd1;
   logic [1:0] s_gnt, s_rv, s_err;
   task automatic check(input string tag, input logic [127:0] o, input logic [127:0] e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask
   task automatic tick(input string tag);
      logic [31:0] a, erd [2];
      logic [1:0] eg, erv, eerr;
      logic em_req, tmo_hit, rv, grant;
      int win;
      a = '0; eg = '0; erv = '0; eerr = '0; erd[0] = '0; erd[1] = '0;
      em_req = 1'b0; rv = 1'b0; grant = 1'b0; win = 0;
      mem_rvalid_i = mem_resp | stray;
      mem_rdata_i = mem_resp ? resp_word : stray ? $urandom : '0;
      @(negedge clk);
      if (!rst && !busy) begin
         win = (m0_req_i && m1_req_i) ? prefer : (m1_req_i ? 1 : 0);
         a = win ? m1_addr_i : m0_addr_i;
         a[1:0] = 2'b00;
         em_req = m0_req_i | m1_req_i;
         if (!em_req) a = '0;
         grant = em_req & mem_gnt_i;
         eg[win] = grant;
      end else if (!rst) begin
         tmo_hit = (age == TMO - 1) && !mem_rvalid_i;
         rv = mem_rvalid_i || tmo_hit;
         erv[who] = rv;
         eerr[who] = tmo_hit;
         if (mem_rvalid_i) erd[who] = mem_rdata_i;
      end
      s_mem_req = mem_req_o; s_mem_addr = mem_addr_o;
      s_gnt = {m1_gnt_o, m0_gnt_o}; s_rv = {m1_rvalid_o, m0_rvalid_o}; s_err = {m1_err_o, m0_err_o};
      s_rd0 = m0_rdata_o; s_rd1 = m1_rdata_o;
      check(tag, {s_mem_req, s_mem_addr, s_gnt, s_rv, s_err, s_rd0, s_rd1},
            {em_req, a, eg, erv, eerr, erd[0], erd[1]});
      @(posedge clk);
      mem_resp = 1'b0;
      if (rst) begin
         busy = 1'b0; prefer = 0; age = 0;
      end else if (!busy) begin
         if (grant) begin
            busy = 1'b1; who = win; age = 1; prefer = 1 - win;
            if (a < MEM_WORDS * 4) begin
               mem_resp = 1'b1;
               resp_word = mem[a[7:2]];
            end
         end
      end else if (rv) busy = 1'b0;
      else age++;
      #1;
   endtask
   initial begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'hC0DE_0000 + i;
      rst = 1'b1; m0_req_i = 0; m1_req_i = 0; m0_addr_i = '0; m1_addr_i = '0; mem_gnt_i = 0;
      busy = 0; mem_resp = 0; stray = 0; prefer = 0; age = 0; who = 0;
      tick("reset"); tick("reset");
      check("reset_outs", {s_mem_req, s_gnt, s_rv, s_err}, '0);
      rst = 1'b0;
      stray = 1;
      for (int i = 0; i < 3; i++) begin
         tick("stray_idle");
         check("stray_idle_rv", s_rv, 2'b00);
      end
      stray = 0;
      m0_req_i = 1; m0_addr_i = 32'h0C; mem_gnt_i = 1;
      tick("single_grant");
      check("single_addr", s_mem_addr, 32'h0C);
      check("single_gnt", s_gnt, 2'b01);
      m0_req_i = 0;
      tick("single_data");
      check("single_rv", {s_rv, s_err}, 4'b0100);
      check("single_rdata", {s_rd0, s_rd1}, {32'hC0DE_0003, 32'h0});
      tick("idle");
      rst = 1; tick("reset2"); rst = 0;
      m0_req_i = 1; m1_req_i = 1; m0_addr_i = 32'h10; m1_addr_i = 32'h20;
      for (int i = 0; i < 8; i++) begin
         tick("alternate");
         if (i % 2 == 0) check("alt_gnt", s_gnt, (i % 4 == 0) ? 2'b01 : 2'b10);
         else check("alt_rv", s_rv, (i % 4 == 1) ? 2'b01 : 2'b10);
      end
      m0_req_i = 0; m1_req_i = 0;
      tick("idle");
      m0_req_i = 1; m0_addr_i = 32'h0E;
      tick("unaligned");
      check("unaligned_addr", s_mem_addr, 32'h0C);
      m0_req_i = 0;
      tick("unaligned_data");
      m1_req_i = 1; m1_addr_i = 32'h1000;
      tick("tmo_grant");
      check("tmo_gnt", s_gnt, 2'b10);
      m1_req_i = 0;
      for (int k = 1; k <= 7; k++) begin
         tick("tmo_wait");
         if (k < 7) check("tmo_quiet", s_rv, 2'b00);
         else check("tmo_err", {s_rv, s_err, s_rd1}, {2'b10, 2'b10, 32'h0});
      end
      tick("tmo_after");
      check("tmo_idle", {s_rv, s_err}, 4'b0000);
      m0_req_i = 1; m0_addr_i = 32'h2000;
      tick("coincide_grant");
      m0_req_i = 0;
      for (int k = 1; k < 7; k++) tick("coincide_wait");
      stray = 1;
      tick("coincide");
      check("coincide_ok", {s_rv, s_err}, 4'b0100);
      stray = 0;
      m0_req_i = 1; m0_addr_i = 32'h04;
      tick("rst_grant");
      m0_req_i = 0; rst = 1;
      tick("rst_wait");
      check("rst_wait_rv", s_rv, 2'b00);
      rst = 0; stray = 1;
      tick("rst_late");
      check("rst_late_rv", s_rv, 2'b00);
      stray = 0; m0_req_i = 1; m1_req_i = 1;
      tick("rst_tie");
      check("rst_tie_gnt", s_gnt, 2'b01);
      m0_req_i = 0; m1_req_i = 0;
      tick("rst_tie_data");
      for (int i = 0; i < 400; i++) begin
         rst = $urandom_range(0, 49) == 0;
         m0_req_i = $urandom_range(0, 1) == 1;
         m1_req_i = $urandom_range(0, 1) == 1;
         m0_addr_i = $urandom_range(0, 9) == 0 ? 32'h1000 + $urandom_range(0, 255) : $urandom_range(0, 255);
         m1_addr_i = $urandom_range(0, 9) == 0 ? 32'h1000 + $urandom_range(0, 255) : $urandom_range(0, 255);
         mem_gnt_i = $urandom_range(0, 9) < 7;
         stray = $urandom_range(0, 19) == 0;
         tick("random");
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
